// File: rtl/adlv_iter.sv
// adlv_iter: sequential limited-carry adder level.
// Each clock applies one carry-limited cell level to (u, l) and produces the pair (s, e).
// The pair satisfies s + 2*e == u + l (mod 2^W), where W = BIT + SPA.
// Optional macro ADLV_EXACT_ITER_EN: the block repeats the level until e == 0,
// or until MAX_ITER levels have been applied.
module adlv_iter #(
   parameter int unsigned BIT      = 16,
   parameter int unsigned SPA      = 1,
   parameter int unsigned MAX_ITER = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [BIT-1:0]                       A,
   input  logic [BIT-1:0]                       B,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [BIT+SPA-1:0]                   s_out,
   output logic [BIT+SPA-1:0]                   e_out,
   output logic [$clog2(MAX_ITER+1)-1:0]        iter_cnt,
   output logic                                 exact
);

   localparam int unsigned W  = BIT + SPA;
   localparam int unsigned CW = $clog2(MAX_ITER + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   logic [1:0]    state_q;
   logic [W-1:0]  u_q, l_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_nxt;
   logic [W-1:0]  g_c, s_c, e_c;
   logic          calc_done;

   // One cell level: each bit sees only the generate of the bit directly below it
   always_comb begin
      g_c = {u_q[W-2:0] & l_q[W-2:0], 1'b0};
      s_c = u_q ^ l_q ^ g_c;
      e_c = (u_q ^ l_q) & g_c;
   end

   assign cnt_nxt = cnt_q + 1'b1;

`ifdef ADLV_EXACT_ITER_EN
   assign calc_done = (e_c == '0) || (cnt_nxt == CW'(MAX_ITER));
`else
   assign calc_done = 1'b1;
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == HOLD);
   assign exact     = (e_out == '0);

   // Control FSM, working operands and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         u_q      <= '0;
         l_q      <= '0;
         cnt_q    <= '0;
         s_out    <= '0;
         e_out    <= '0;
         iter_cnt <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  u_q     <= {{SPA{1'b0}}, A};
                  l_q     <= {B, {SPA{1'b0}}};
                  cnt_q   <= '0;
                  state_q <= CALC;
               end
            end
            CALC: begin
               cnt_q <= cnt_nxt;
               if (calc_done) begin
                  // Result registers only move here, so they stay frozen through HOLD and IDLE
                  s_out    <= s_c;
                  e_out    <= e_c;
                  iter_cnt <= cnt_nxt;
                  state_q  <= HOLD;
               end else begin
                  u_q <= s_c;
                  l_q <= {e_c[W-2:0], 1'b0};
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
